i2s_tdm_enc: RTL and testbench

Serial-audio transmitter (clock master) for I2S and TDM links. It generates bclk and lrclk from mclk and accepts parallel samples tagged with a channel over a valid/ready handshake. Each sample is held in a per-channel buffer and shifted out MSB-first in its frame slot. It sits between the audio processing fabric and a DAC/codec serial input, as the transmit counterpart of the I2S/TDM decoder.

---
 rtl/i2s_tdm_enc.sv | 121 ++++++++++++
 tb/tb_i2s_tdm_enc.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/i2s_tdm_enc.sv
// I2S/TDM serial audio transmitter (clock master): divides mclk into bclk/lrclk and shifts
// per-channel buffered samples out MSB-first in their frame slots.
module i2s_tdm_enc #(
  parameter int unsigned NR_CHANNELS     = 4,
  parameter int unsigned INPUT_WIDTH     = 24,
  parameter int unsigned SLOT_WIDTH      = 32,
  parameter bit          LRCLK_POLARITY  = 1'b1,
  parameter bit          LEFT_ALIGNED    = 1'b1,
  parameter int unsigned MCLK_BCLK_RATIO = 4
) (
  input  logic                           mclk,
  input  logic                           rst,
  input  logic [INPUT_WIDTH-1:0]         i2s_tdm_d,
  input  logic [$clog2(NR_CHANNELS)-1:0] i2s_tdm_ch,
  input  logic                           i2s_tdm_dv,
  output logic                           i2s_tdm_dr,
  output logic                           bclk,
  output logic                           lrclk,
  output logic                           i2s_tdm,
  output logic                           i2s_tdm_ur
);

  localparam int unsigned ChW  = $clog2(NR_CHANNELS);
  localparam int unsigned BitW = $clog2(SLOT_WIDTH);
  localparam int unsigned CntW = $clog2(MCLK_BCLK_RATIO);
  // Bit-in-slot index at which a slot's MSB goes out (one bclk late in I2S mode).
  localparam logic [BitW-1:0] MsbBit = LEFT_ALIGNED ? '0 : BitW'(1);

  if (NR_CHANNELS < 2 || (NR_CHANNELS % 2) != 0 || INPUT_WIDTH < 8 ||
      SLOT_WIDTH < INPUT_WIDTH || MCLK_BCLK_RATIO < 2 || (MCLK_BCLK_RATIO % 2) != 0)
  begin : g_bad_params
    $error("i2s_tdm_enc: illegal parameter combination");
  end

  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [BitW-1:0]        bit_q, bit_d;
  logic [ChW-1:0]         slot_q, slot_d;
  logic [INPUT_WIDTH-1:0] sr_q;
  logic [NR_CHANNELS-1:0] fresh_q;
  logic [INPUT_WIDTH-1:0] sample_q [NR_CHANNELS];

  logic                   tick;
  logic                   load;
  logic                   fresh_k;
  logic [INPUT_WIDTH-1:0] load_val;
  logic                   wr;

  // The tick is the mclk edge on which the divider wraps, i.e. the bclk falling edge.
  assign tick = (cnt_q == CntW'(MCLK_BCLK_RATIO - 1));
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  // Frame position p is kept as {slot, bit-in-slot}; these are its values after this edge.
  always_comb begin
    bit_d  = bit_q;
    slot_d = slot_q;
    if (tick) begin
      if (bit_q == BitW'(SLOT_WIDTH - 1)) begin
        bit_d  = '0;
        slot_d = (slot_q == ChW'(NR_CHANNELS - 1)) ? '0 : slot_q + 1'b1;
      end else begin
        bit_d = bit_q + 1'b1;
      end
    end
  end

  assign load     = tick && (bit_d == MsbBit);
  assign fresh_k  = fresh_q[slot_d];
  assign load_val = sample_q[slot_d];

  assign i2s_tdm_dr = ~rst & ~fresh_q[i2s_tdm_ch];
  assign wr         = i2s_tdm_dv & i2s_tdm_dr;

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      cnt_q      <= CntW'(MCLK_BCLK_RATIO - 1);
      bit_q      <= BitW'(SLOT_WIDTH - 1);
      slot_q     <= ChW'(NR_CHANNELS - 1);
      sr_q       <= '0;
      bclk       <= 1'b0;
      lrclk      <= ~LRCLK_POLARITY;
      i2s_tdm    <= 1'b0;
      i2s_tdm_ur <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      slot_q     <= slot_d;
      bclk       <= (cnt_d >= CntW'(MCLK_BCLK_RATIO / 2));
      i2s_tdm_ur <= load & ~fresh_k;
      if (tick) begin
        lrclk <= (slot_d < ChW'(NR_CHANNELS / 2)) ? LRCLK_POLARITY : ~LRCLK_POLARITY;
        if (load) begin
          i2s_tdm <= fresh_k & load_val[INPUT_WIDTH-1];
          sr_q    <= fresh_k ? (load_val << 1) : '0;
        end else begin
          // Zeros shift in behind the sample to pad the rest of the slot.
          i2s_tdm <= sr_q[INPUT_WIDTH-1];
          sr_q    <= sr_q << 1;
        end
      end
    end
  end

  // A load never clears a channel being written: dr is low while that channel is fresh.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      fresh_q <= '0;
      for (int i = 0; i < int'(NR_CHANNELS); i++) begin
        sample_q[i] <= '0;
      end
    end else begin
      if (load && fresh_k) begin
        fresh_q[slot_d] <= 1'b0;
      end
      if (wr) begin
        fresh_q[i2s_tdm_ch]  <= 1'b1;
        sample_q[i2s_tdm_ch] <= i2s_tdm_d;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tdm_enc.sv
// Scoreboard bench for i2s_tdm_enc: TDM defaults, a two-channel I2S link and a ratio-2 divider
// run side by side; a bench receiver checks clocks, underruns and every loaded slot word.
module tb_i2s_tdm_enc;

  localparam int NI = 3;
  localparam int SW = 32;
  localparam int NCH [NI] = '{4, 2, 4};
  localparam int RAT [NI] = '{4, 4, 2};
  localparam int DLY [NI] = '{0, 1, 0};
  localparam bit POL [NI] = '{1'b1, 1'b0, 1'b1};

  typedef struct {
    int          k;
    logic [31:0] w;
  } slot_t;

  logic        mclk = 1'b0;
  logic        rst  = 1'b1;
  logic [2:0]  bclk_w, lrclk_w, sd_w, ur_w, dr_w, dv_w;
  logic [23:0] d_w [NI];
  logic [1:0]  ch_a, ch_c;
  logic        ch_b;
  int          ea;
  int          n_chk = 0;
  int          n_err = 0;

  slot_t       sb_q [NI][$];
  bit          pend_ok [NI][4];
  int          pend_e  [NI][4];
  logic [23:0] pend_v  [NI][4];
  logic [31:0] sh      [NI];

  i2s_tdm_enc #(.NR_CHANNELS(4), .INPUT_WIDTH(24), .SLOT_WIDTH(32), .LRCLK_POLARITY(1'b1),
                .LEFT_ALIGNED(1'b1), .MCLK_BCLK_RATIO(4)) u_tdm (
    .mclk(mclk), .rst(rst), .i2s_tdm_d(d_w[0]), .i2s_tdm_ch(ch_a), .i2s_tdm_dv(dv_w[0]),
    .i2s_tdm_dr(dr_w[0]), .bclk(bclk_w[0]), .lrclk(lrclk_w[0]), .i2s_tdm(sd_w[0]),
    .i2s_tdm_ur(ur_w[0]));

  i2s_tdm_enc #(.NR_CHANNELS(2), .INPUT_WIDTH(24), .SLOT_WIDTH(32), .LRCLK_POLARITY(1'b0),
                .LEFT_ALIGNED(1'b0), .MCLK_BCLK_RATIO(4)) u_i2s (
    .mclk(mclk), .rst(rst), .i2s_tdm_d(d_w[1]), .i2s_tdm_ch(ch_b), .i2s_tdm_dv(dv_w[1]),
    .i2s_tdm_dr(dr_w[1]), .bclk(bclk_w[1]), .lrclk(lrclk_w[1]), .i2s_tdm(sd_w[1]),
    .i2s_tdm_ur(ur_w[1]));

  i2s_tdm_enc #(.NR_CHANNELS(4), .INPUT_WIDTH(24), .SLOT_WIDTH(32), .LRCLK_POLARITY(1'b1),
                .LEFT_ALIGNED(1'b1), .MCLK_BCLK_RATIO(2)) u_fast (
    .mclk(mclk), .rst(rst), .i2s_tdm_d(d_w[2]), .i2s_tdm_ch(ch_c), .i2s_tdm_dv(dv_w[2]),
    .i2s_tdm_dr(dr_w[2]), .bclk(bclk_w[2]), .lrclk(lrclk_w[2]), .i2s_tdm(sd_w[2]),
    .i2s_tdm_ur(ur_w[2]));

  always #5 mclk = ~mclk;

  // Edge index since reset release; edge 0 is the first tick with p = 0.
  always @(posedge mclk or posedge rst) begin
    if (rst) ea <= -1;
    else     ea <= ea + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, ea);
    end
  endtask

  task automatic mon(input int i);
    int    f, r, p, q, kk;
    bit    exp_ur;
    slot_t s;
    f = NCH[i] * SW;
    r = RAT[i];
    if (rst) begin
      check($sformatf("u%0d rst bclk", i), 32'(bclk_w[i]), 32'(1'b0));
      check($sformatf("u%0d rst lrclk", i), 32'(lrclk_w[i]), 32'(!POL[i]));
      check($sformatf("u%0d rst data", i), 32'(sd_w[i]), 32'(1'b0));
      check($sformatf("u%0d rst ur", i), 32'(ur_w[i]), 32'(1'b0));
      check($sformatf("u%0d rst dr", i), 32'(dr_w[i]), 32'(1'b0));
      sb_q[i].delete();
      for (int c = 0; c < 4; c++) pend_ok[i][c] = 1'b0;
      return;
    end
    p = (ea / r) % f;
    q = (p - DLY[i] + f) % f;
    check($sformatf("u%0d bclk", i), 32'(bclk_w[i]), 32'((ea % r) >= r / 2));
    check($sformatf("u%0d lrclk", i), 32'(lrclk_w[i]), 32'((p < f / 2) ? POL[i] : !POL[i]));
    exp_ur = 1'b0;
    if ((ea % r) == 0 && (q % SW) == 0) begin
      kk  = q / SW;
      s.k = kk;
      // A sample counts for this slot only if accepted strictly before its MSB tick.
      if (pend_ok[i][kk] && pend_e[i][kk] < ea) begin
        s.w = {pend_v[i][kk], 8'h00};
        pend_ok[i][kk] = 1'b0;
      end else begin
        s.w    = 32'h0;
        exp_ur = 1'b1;
      end
      sb_q[i].push_back(s);
    end
    check($sformatf("u%0d ur", i), 32'(ur_w[i]), 32'(exp_ur));
    if ((ea % r) == r / 2) begin
      sh[i] = {sh[i][30:0], sd_w[i]};
      if ((q % SW) == SW - 1 && sb_q[i].size() > 0) begin
        s = sb_q[i].pop_front();
        check($sformatf("u%0d slot idx", i), 32'(q / SW), 32'(s.k));
        check($sformatf("u%0d slot%0d data", i, s.k), sh[i], s.w);
      end
    end
  endtask

  always @(negedge mclk) begin
    for (int i = 0; i < NI; i++) mon(i);
  end

  // Drive one write attempt (en = 0 only probes dr); at >= 0 pins the accepting edge.
  task automatic wr(input int i, input int ch, input logic [23:0] d, input int at, input bit en);
    bit exp_dr;
    @(negedge mclk);
    while (at >= 0 && ea < at - 1) @(negedge mclk);
    if (at >= 0) check("wr timing", ea, at - 1);
    #1;
    case (i)
      0:       ch_a = ch[1:0];
      1:       ch_b = ch[0];
      default: ch_c = ch[1:0];
    endcase
    d_w[i]  = d;
    dv_w[i] = en;
    #1;
    exp_dr = !pend_ok[i][ch];
    check($sformatf("u%0d dr ch%0d", i, ch), 32'(dr_w[i]), 32'(exp_dr));
    if (en && exp_dr) begin
      pend_ok[i][ch] = 1'b1;
      pend_e[i][ch]  = ea + 1;
      pend_v[i][ch]  = d;
    end
    @(posedge mclk);
    #1;
    dv_w[i] = 1'b0;
  endtask

  initial begin
    dv_w = '0;
    ch_a = '0;
    ch_b = 1'b0;
    ch_c = '0;
    for (int i = 0; i < NI; i++) begin
      d_w[i] = '0;
      sh[i]  = '0;
    end
    repeat (3) @(negedge mclk);
    #1 rst = 1'b0;

    // First TDM frame carries nothing; then fill all four channels for the second frame.
    while (ea < 400) @(negedge mclk);
    wr(0, 0, 24'h800001, -1, 1'b1);
    wr(0, 1, 24'h7FFFFF, -1, 1'b1);
    wr(0, 2, 24'h000000, -1, 1'b1);
    wr(0, 3, 24'hA5A5A5, -1, 1'b1);
    wr(1, 0, 24'hC00001, -1, 1'b1);

    // Second write to ch1 before its slot must be refused.
    while (ea < 700) @(negedge mclk);
    wr(0, 1, 24'h123456, -1, 1'b1);
    wr(0, 1, 24'h654321, -1, 1'b1);

    // Write landing exactly on ch2's MSB tick of the fast instance.
    wr(2, 2, 24'h5A5A5A, 896, 1'b1);

    while (ea < 1290) @(negedge mclk);
    for (int c = 0; c < 4; c++) wr(0, c, 24'h0, -1, 1'b0);
    wr(0, 2, 24'h777777, -1, 1'b1);

    // Asynchronous reset mid-slot while bclk of the TDM instance is high.
    while (ea < 1310 || (ea % 4) != 2) @(negedge mclk);
    #1 rst = 1'b1;
    #1;
    check("async rst bclk", 32'(bclk_w), 32'(3'b000));
    check("async rst lrclk", 32'(lrclk_w), 32'(3'b010));
    check("async rst data", 32'(sd_w), 32'(3'b000));
    repeat (3) @(negedge mclk);
    #1 rst = 1'b0;
    wr(0, 2, 24'h0, -1, 1'b0);
    while (ea < 600) @(negedge mclk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000ns");
    $fatal(1, "timeout");
  end

endmodule
